// File: rtl/arbiter_8x3.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_8x3
//  Description : Round-robin arbiter sharing one resource among 8 requesters.
//                A grant is held for the whole transaction and released when
//                the owner drops its request. The previous owner has the
//                lowest priority at the next arbitration.
//  Ports       : clk         - rising-edge clock
//                rst         - synchronous reset, active-high
//                req[7:0]    - request vector, held high for a transaction
//                grant[7:0]  - registered one-hot grant, 8'h00 when idle
//                grant_idx   - encoded grant index, idx = 7 - p, 0 when idle
//                grant_valid - high while any grant is active
//                timeout     - 1-cycle pulse on a forced release
//  Option      : LOCK_TIMEOUT_EN - when defined, a grant is forcibly
//                released after HOLD_MAX consecutive cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbiter_8x3 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0] r_state;
    logic [2:0] r_last;
    logic [7:0] r_grant;
    logic [2:0] r_idx;

    logic [0:0] w_state_nxt;
    logic [2:0] w_last_nxt;
    logic [7:0] w_grant_nxt;
    logic [2:0] w_idx_nxt;

    logic       w_found;
    logic [2:0] w_win;
    logic [2:0] w_pos;
    logic       w_force;

    // ------------------------------------------------------------------
    // Winner search: positions last-1, last-2, ... wrapping through 0->7
    // and ending at last itself, so the previous owner is checked last.
    // The 3-bit subtraction provides the wrap for free.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_pos   = r_last;
        for (int i = 1; i <= 8; i++) begin
            w_pos = r_last - 3'(i);
            if (!w_found && req[w_pos]) begin
                w_win   = w_pos;
                w_found = 1'b1;
            end
        end
    end

`ifdef LOCK_TIMEOUT_EN
    localparam logic [7:0] c_HOLD_LIM = 8'(HOLD_MAX - 1);

    logic [7:0] r_hold_cnt;
    logic       r_timeout;

    // Forced release only when the owner still requests; a drop on the
    // same edge is an ordinary release without a timeout pulse.
    assign w_force = (r_state == S_GRANT) && req[r_last] && (r_hold_cnt == c_HOLD_LIM);

    // Counter sits at 0 in IDLE, so it reads 0 during the first grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (r_state == S_GRANT) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end else begin
                r_hold_cnt <= 8'd0;
            end
        end
    end
`else
    logic w_unused_hold;
    assign w_unused_hold = (HOLD_MAX == 0);
    assign w_force       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 3'd0;
            r_grant <= 8'h00;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = 8'h01 << w_win;
                    w_idx_nxt   = ~w_win;
                    w_last_nxt  = w_win;
                end
            end
            S_GRANT: begin
                // Other requesters are ignored here: no preemption.
                if (!req[r_last] || w_force) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = 8'h00;
                    w_idx_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 8'h00;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        grant       = r_grant;
        grant_idx   = r_idx;
        grant_valid = |r_grant;
`ifdef LOCK_TIMEOUT_EN
        timeout     = r_timeout;
`else
        timeout     = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_arbiter_8x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbiter_8x3
//  Description : Self-checking bench for arbiter_8x3. Each scenario task
//                queues stimulus, pushes the expected outputs to a scoreboard
//                as each cycle is driven and pops/compares them after the
//                clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_8x3;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    logic [12:0] obs;
    assign obs = {grant, grant_idx, grant_valid, timeout};

    typedef struct packed {
        logic        rst;
        logic [7:0]  req;
        logic        pulse;
        logic [12:0] exp;
    } stim_t;

    stim_t       st_q[$];
    logic [12:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    arbiter_8x3 #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word {grant, idx, valid, timeout}; idx = 7 - p.
    function automatic logic [12:0] ex(input logic [7:0] g, input logic to);
        logic [2:0] idx;
        idx = 3'd0;
        for (int p = 0; p < 8; p++) if (g[p]) idx = 3'(7 - p);
        return {g, idx, |g, to};
    endfunction

    task automatic stim(input logic r, input logic [7:0] q, input logic [7:0] g, input logic to);
        st_q.push_back('{r, q, 1'b0, ex(g, to)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        logic [12:0] e;
        int n = 0;
        stim(1, 8'hFF, 8'h00, 0);
        stim(1, 8'hFF, 8'h00, 0);
        stim(0, 8'hFF, 8'h80, 0);
        stim(0, 8'h00, 8'h00, 0);
        stim(0, 8'h00, 8'h00, 0);
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            rst = s.rst; req = s.req;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset cyc%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_single();
        stim_t s;
        logic [12:0] e;
        int n = 0;
        stim(0, 8'h04, 8'h04, 0);
        stim(0, 8'h04, 8'h04, 0);
        stim(0, 8'h00, 8'h00, 0);
        stim(0, 8'h00, 8'h00, 0);
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            rst = s.rst; req = s.req;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL single cyc%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_rotation();
        stim_t s;
        logic [12:0] e;
        logic [7:0] g;
        int n = 0;
        stim(1, 8'h00, 8'h00, 0);
        for (int k = 0; k < 9; k++) begin
            g = 8'h01 << (7 - (k % 8));
            stim(0, 8'hFF, g, 0);
            stim(0, 8'hFF, g, 0);
            stim(0, 8'hFF, g, 0);
            stim(0, 8'hFF & ~g, 8'h00, 0);
        end
        stim(0, 8'h00, 8'h00, 0);
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            rst = s.rst; req = s.req;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL rotation cyc%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_no_preempt();
        stim_t s;
        logic [12:0] e;
        int n = 0;
        stim(0, 8'h01, 8'h01, 0);
        stim(0, 8'h81, 8'h01, 0);
        stim(0, 8'h81, 8'h01, 0);
        stim(0, 8'h81, 8'h01, 0);
        stim(0, 8'h80, 8'h00, 0);
        stim(0, 8'h80, 8'h80, 0);
        stim(0, 8'h00, 8'h00, 0);
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            rst = s.rst; req = s.req;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL no_preempt cyc%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_mid_reset();
        stim_t s;
        logic [12:0] e;
        int n = 0;
        stim(0, 8'h10, 8'h10, 0);
        stim(0, 8'h10, 8'h10, 0);
        stim(1, 8'h10, 8'h00, 0);
        stim(0, 8'hFF, 8'h80, 0);
        stim(0, 8'h00, 8'h00, 0);
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            rst = s.rst; req = s.req;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL mid_reset cyc%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    // Owner drops and a new requester rises at the same edge, then a
    // request pulse that vanishes between edges.
    task automatic test_handover_pulse();
        stim_t s;
        logic [12:0] e;
        int n = 0;
        stim(0, 8'h80, 8'h80, 0);
        stim(0, 8'h80, 8'h80, 0);
        stim(0, 8'h40, 8'h00, 0);
        stim(0, 8'h40, 8'h40, 0);
        stim(0, 8'h00, 8'h00, 0);
        st_q.push_back('{1'b0, 8'h02, 1'b1, ex(8'h00, 0)});
        stim(0, 8'h00, 8'h00, 0);
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            rst = s.rst; req = s.req;
            exp_q.push_back(s.exp);
            if (s.pulse) begin
                #2 req = 8'h00;
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL handover_pulse cyc%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        logic [12:0] e;
        int n = 0;
`ifdef LOCK_TIMEOUT_EN
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) stim(0, 8'h20, 8'h20, 0);
            stim(0, 8'h20, 8'h00, 1);
        end
        stim(0, 8'h20, 8'h20, 0);
        stim(0, 8'h00, 8'h00, 0);
        // Owner drops exactly at the limit edge: ordinary release.
        for (int c = 0; c < 4; c++) stim(0, 8'h20, 8'h20, 0);
        stim(0, 8'h00, 8'h00, 0);
        stim(0, 8'h00, 8'h00, 0);
`else
        for (int c = 0; c < 100; c++) stim(0, 8'h20, 8'h20, 0);
        stim(0, 8'h00, 8'h00, 0);
`endif
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            rst = s.rst; req = s.req;
            exp_q.push_back(s.exp);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL timeout cyc%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        test_reset();
        test_single();
        test_rotation();
        test_no_preempt();
        test_mid_reset();
        test_handover_pulse();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
